// File: rtl/adc_seq_pkg.sv
// ----------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC sample sequencer:
//   state_t        - sequencer FSM states
//   frame_w()      - daisy-chain frame width, 18 bits per ADC
//   DEFAULT_CNT_W  - default width of sample count, period and index
// ----------------------------------------------------------------------------
package adc_seq_pkg;

   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT,
      ST_ACK,
      ST_GAP,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic int frame_w(input int num_adc);
      return 18 * num_adc;
   endfunction

endpackage

// File: rtl/adc_seq_period_timer.sv
// ----------------------------------------------------------------------------
// adc_seq_period_timer
// Measures clocks elapsed since the last conversion trigger and flags when the
// programmed start-to-start period has been reached.
//   clk, rst_n  - clock, asynchronous active-low reset
//   restart     - high in the trigger cycle; that cycle counts as 0
//   period      - minimum clocks between triggers (0 and 1 mean back-to-back)
//   expired     - count >= period-1, i.e. a trigger issued next cycle keeps
//                 exactly 'period' clocks of spacing
// ----------------------------------------------------------------------------
module adc_seq_period_timer
   import adc_seq_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic [CNT_W-1:0] period,
   output logic             expired
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // The restart cycle itself is count 0, so the register holds 1 on the
   // following cycle; count then tracks clocks since the trigger exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart) begin
         count <= CNT_ONE;
      end else if (count != '1) begin
         count <= count + CNT_ONE;
      end
   end

   // period-1 would wrap for period=0, so small periods are handled apart.
   assign expired = (period <= CNT_ONE) || (count >= period - CNT_ONE);

endmodule

// File: rtl/adc_sample_sequencer.sv
// ----------------------------------------------------------------------------
// adc_sample_sequencer
// Runs a host-commanded series of conversions on the daisy-chained ADC
// readout controller and streams each frame out through a one-entry result
// register.
//   clk, rst_n              - clock, asynchronous active-low reset
//   start, num_samples,
//   period                  - run command; count and period latched at start
//   abort                   - level; ends the run after any in-flight frame
//   busy, done, aborted     - run status; aborted is valid with done
//   adc_trigger             - one-cycle conversion request to the controller
//   adc_ready, adc_dout     - controller holds a completed frame
//   adc_ack                 - one-cycle release of the controller
//   res_valid, res_ready    - result handshake
//   res_data, res_index     - captured frame and its sample number
// ----------------------------------------------------------------------------
module adc_sample_sequencer
   import adc_seq_pkg::*;
#(
   parameter int NUM_ADC = 3,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [CNT_W-1:0]             num_samples,
   input  logic [CNT_W-1:0]             period,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic                         aborted,
   output logic                         adc_trigger,
   input  logic                         adc_ready,
   input  logic [frame_w(NUM_ADC)-1:0]  adc_dout,
   output logic                         adc_ack,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [frame_w(NUM_ADC)-1:0]  res_data,
   output logic [CNT_W-1:0]             res_index
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] sample_cnt;
   logic             abort_pend;
   logic             timer_expired;
   logic             capture;
   logic             last_sample;
   logic             abort_seen;

   // A frame may be taken when the register is empty or being emptied now;
   // otherwise the controller is left holding it (backpressure).
   assign capture     = adc_ready && (!res_valid || res_ready);
   assign last_sample = (sample_cnt == num_q);
   assign abort_seen  = abort || abort_pend;

   // adc_trigger is high exactly in the TRIG cycle, which is timer count 0.
   adc_seq_period_timer #(
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (adc_trigger),
      .period  (period_q),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         adc_trigger <= 1'b0;
         adc_ack     <= 1'b0;
         res_valid   <= 1'b0;
         num_q       <= '0;
         period_q    <= '0;
         sample_cnt  <= '0;
         abort_pend  <= 1'b0;
      end else begin
         adc_trigger <= 1'b0;
         adc_ack     <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  abort_pend <= 1'b0;
                  sample_cnt <= '0;
                  // An empty run still reports through DRAIN/DONE.
                  if (num_samples == '0) begin
                     state <= ST_DRAIN;
                  end else begin
                     num_q       <= num_samples;
                     period_q    <= period;
                     adc_trigger <= 1'b1;
                     state       <= ST_TRIG;
                  end
               end
            end

            // Abort here only takes effect after the issued frame is acked.
            ST_TRIG: begin
               if (abort) begin
                  abort_pend <= 1'b1;
               end
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (abort) begin
                  abort_pend <= 1'b1;
               end
               if (capture) begin
                  res_valid  <= 1'b1;
                  sample_cnt <= sample_cnt + CNT_ONE;
                  adc_ack    <= 1'b1;
                  state      <= ST_ACK;
               end
            end

            // The result register is full here; if it is taken this cycle the
            // run can finish without a separate drain cycle.
            ST_ACK: begin
               if (abort_seen || last_sample) begin
                  abort_pend <= abort_seen;
                  if (res_ready) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     aborted <= abort_seen;
                     state   <= ST_DONE;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  state <= ST_GAP;
               end
            end

            // At least one GAP cycle lets the controller return to idle.
            ST_GAP: begin
               if (abort) begin
                  abort_pend <= 1'b1;
                  state      <= ST_DRAIN;
               end else if (timer_expired) begin
                  adc_trigger <= 1'b1;
                  state       <= ST_TRIG;
               end
            end

            ST_DRAIN: begin
               if (!res_valid || res_ready) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= abort_pend;
                  state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= '0;
         res_index <= '0;
      end else if ((state == ST_WAIT) && capture) begin
         res_data  <= adc_dout;
         res_index <= sample_cnt;
      end
   end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
module tb_adc_sample_sequencer;

   localparam int NUM_ADC = 3;
   localparam int CNT_W   = 16;
   localparam int FW      = 18 * NUM_ADC;
   localparam logic [FW-1:0] FRAME_BASE = 54'h0A5A5A5A5A5A5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic [CNT_W-1:0] period = '0;
   logic             abort = 1'b0;
   logic             busy, done, aborted, adc_trigger, adc_ack, res_valid;
   logic             adc_ready = 1'b0;
   logic [FW-1:0]    adc_dout = '0;
   logic             res_ready = 1'b1;
   logic [FW-1:0]    res_data;
   logic [CNT_W-1:0] res_index;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // observation logs of the current run
   int            trig_q[$];
   int            ack_q[$];
   int            acc_cyc_q[$];
   int            acc_idx_q[$];
   logic [FW-1:0] acc_data_q[$];
   int            done_q[$];
   bit            done_ab_q[$];
   // reference: frames issued by the controller model, in order
   logic [FW-1:0] exp_frames[$];
   int            lat_q[$];

   // controller model state
   int            m_cnt = 0;
   bit            m_conv = 0;
   bit            m_drop = 0;
   logic [FW-1:0] m_frame = '0;
   int            issued = 0;
   int            acked = 0;
   int            frame_no = 0;
   int            lat_force = 0;

   adc_sample_sequencer #(
      .NUM_ADC (NUM_ADC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_samples (num_samples),
      .period      (period),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .adc_trigger (adc_trigger),
      .adc_ready   (adc_ready),
      .adc_dout    (adc_dout),
      .adc_ack     (adc_ack),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_index   (res_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor, then a controller model that answers each trigger after a
   // latency, holds the frame until acked and frees itself one cycle later.
   always @(negedge clk) begin
      if (rst_n) begin
         if (adc_trigger) begin
            trig_q.push_back(cyc);
            check("trig_while_ready_or_ack", 64'({adc_ready, adc_ack}), 64'd0);
         end
         if (adc_ack) begin
            ack_q.push_back(cyc);
            check("ack_without_frame", 64'(adc_ready), 64'd1);
         end
         if (res_valid && res_ready) begin
            acc_cyc_q.push_back(cyc);
            acc_idx_q.push_back(int'(res_index));
            acc_data_q.push_back(res_data);
         end
         if (done) begin
            done_q.push_back(cyc);
            done_ab_q.push_back(aborted);
            check("busy_at_done", 64'(busy), 64'd0);
         end

         if (m_drop) begin
            adc_ready = 1'b0;
            m_drop = 1'b0;
         end
         if (adc_ack) begin
            m_drop = 1'b1;
            acked++;
         end
         if (adc_trigger) begin
            m_cnt = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
            lat_q.push_back(m_cnt);
            m_frame = FRAME_BASE + FW'(frame_no);
            exp_frames.push_back(m_frame);
            frame_no++;
            issued++;
            m_conv = 1'b1;
         end else if (m_conv) begin
            m_cnt--;
            if (m_cnt == 0) begin
               adc_ready = 1'b1;
               adc_dout = m_frame;
               m_conv = 1'b0;
            end
         end
      end else begin
         adc_ready = 1'b0;
         adc_dout = '0;
         m_conv = 1'b0;
         m_drop = 1'b0;
      end
   end

   task automatic clear_logs();
      trig_q.delete(); ack_q.delete(); acc_cyc_q.delete(); acc_idx_q.delete();
      acc_data_q.delete(); done_q.delete(); done_ab_q.delete();
      exp_frames.delete(); lat_q.delete();
      issued = 0;
      acked = 0;
   endtask

   task automatic run_start(input int n, input int p, output int s);
      num_samples = CNT_W'(n);
      period = CNT_W'(p);
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit rand_ready);
      int t;
      t = 0;
      while (done_q.size() == 0 && t < budget) begin
         if (rand_ready) res_ready = 1'($urandom_range(0, 1));
         tick();
         t++;
      end
      res_ready = 1'b1;
      check({tag, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
   endtask

   task automatic wait_trigs(input string tag, input int want, input int budget);
      int t;
      t = 0;
      while (trig_q.size() < want && t < budget) begin
         tick();
         t++;
      end
      check({tag, "_trig_reached"}, 64'(trig_q.size() >= want), 64'd1);
   endtask

   // Every run: n frames in issue order with indices 0..n-1, one done one
   // cycle after the last accepted result, nothing left unacknowledged.
   task automatic check_run(input string tag, input int n_exp, input bit ab_exp);
      repeat (3) tick();
      check({tag, "_trig_cnt"}, 64'(trig_q.size()), 64'(n_exp));
      check({tag, "_res_cnt"}, 64'(acc_idx_q.size()), 64'(n_exp));
      for (int i = 0; i < acc_idx_q.size() && i < exp_frames.size(); i++) begin
         check({tag, "_index"}, 64'(acc_idx_q[i]), 64'(i));
         check({tag, "_data"}, 64'(acc_data_q[i]), 64'(exp_frames[i]));
      end
      check({tag, "_done_cnt"}, 64'(done_q.size()), 64'd1);
      if (done_q.size() > 0) begin
         check({tag, "_aborted"}, 64'(done_ab_q[0]), 64'(ab_exp));
         if (acc_cyc_q.size() > 0)
            check({tag, "_done_cyc"}, 64'(done_q[0]), 64'(acc_cyc_q[acc_cyc_q.size()-1] + 1));
      end
      check({tag, "_all_acked"}, 64'(acked), 64'(issued));
   endtask

   initial begin
      int s;
      int rel;
      int n;
      int p;
      int d;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_aborted", 64'(aborted), 64'd0);
      check("rst_trigger", 64'(adc_trigger), 64'd0);
      check("rst_ack", 64'(adc_ack), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data", 64'(res_data), 64'd0);
      check("rst_res_index", 64'(res_index), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // A: 4 samples back-to-back
      clear_logs();
      run_start(4, 0, s);
      check("A_busy", 64'(busy), 64'd1);
      wait_done("A", 200, 1'b0);
      if (trig_q.size() == 4) begin
         check("A_first_trig", 64'(trig_q[0]), 64'(s + 1));
         for (int i = 1; i < 4; i++)
            check("A_trig_time", 64'(trig_q[i]), 64'(trig_q[i-1] + lat_q[i-1] + 3));
         if (done_q.size() > 0)
            check("A_done_time", 64'(done_q[0]), 64'(trig_q[3] + lat_q[3] + 2));
      end
      check_run("A", 4, 1'b0);

      // B: period 200; a second start with new settings mid-run is ignored
      clear_logs();
      run_start(3, 200, s);
      wait_trigs("B", 1, 10);
      repeat (5) tick();
      num_samples = CNT_W'(7);
      period = CNT_W'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("B", 1000, 1'b0);
      for (int i = 1; i < trig_q.size(); i++)
         check("B_spacing", 64'(trig_q[i] - trig_q[i-1]), 64'd200);
      check_run("B", 3, 1'b0);

      // C: result held 50 cycles, controller kept waiting
      clear_logs();
      res_ready = 1'b0;
      run_start(2, 0, s);
      d = 0;
      while (!res_valid && d < 50) begin
         tick();
         d++;
      end
      check("C_first_result", 64'(res_valid), 64'd1);
      repeat (50) tick();
      rel = cyc;
      check("C_frame_held", 64'(adc_ready), 64'd1);
      check("C_ack_count_held", 64'(ack_q.size()), 64'd1);
      res_ready = 1'b1;
      wait_done("C", 100, 1'b0);
      if (ack_q.size() == 2) check("C_ack2_time", 64'(ack_q[1]), 64'(rel + 1));
      if (done_q.size() > 0) check("C_done_time", 64'(done_q[0]), 64'(rel + 2));
      check_run("C", 2, 1'b0);

      // D: abort while the 3rd conversion is in flight
      clear_logs();
      run_start(10, 0, s);
      wait_trigs("D", 3, 100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("D", 200, 1'b0);
      check_run("D", 3, 1'b1);

      // E: zero-sample run
      clear_logs();
      run_start(0, 5, s);
      check("E_busy", 64'(busy), 64'd1);
      wait_done("E", 10, 1'b0);
      if (done_q.size() > 0) check("E_done_time", 64'(done_q[0]), 64'(s + 2));
      check_run("E", 0, 1'b0);

      // F: reset in WAIT, then a normal run
      clear_logs();
      lat_force = 20;
      run_start(5, 0, s);
      wait_trigs("F", 1, 10);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check("F_rst_busy", 64'(busy), 64'd0);
      check("F_rst_trigger", 64'(adc_trigger), 64'd0);
      check("F_rst_ack", 64'(adc_ack), 64'd0);
      check("F_rst_res_valid", 64'(res_valid), 64'd0);
      check("F_rst_res_data", 64'(res_data), 64'd0);
      check("F_rst_done", 64'({done, aborted}), 64'd0);
      repeat (2) tick();
      check("F_no_done", 64'(done_q.size()), 64'd0);
      rst_n = 1'b1;
      lat_force = 0;
      clear_logs();
      tick();
      run_start(2, 3, s);
      wait_done("F2", 100, 1'b0);
      check_run("F2", 2, 1'b0);

      // R: random runs with random downstream backpressure
      for (int r = 0; r < 4; r++) begin
         clear_logs();
         n = int'($urandom_range(1, 6));
         p = int'($urandom_range(0, 12));
         run_start(n, p, s);
         wait_done("R", 2000, 1'b1);
         for (int i = 1; i < trig_q.size(); i++) begin
            d = trig_q[i] - trig_q[i-1];
            check("R_spacing", 64'((d >= p) && (d >= lat_q[i-1] + 3)), 64'd1);
         end
         check_run("R", n, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
